// File: rtl/fifo_flex.sv
// Show-ahead synchronous FIFO with programmable almost flags,
// occupancy count and sticky overflow/underflow errors.
module fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_L  = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_L  = (ADDR_WIDTH+1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] DEP_L = (ADDR_WIDTH+1)'(DEPTH);

   generate
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
         $error("fifo_flex: AF_LEVEL out of range");
      end
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_ae_chk
         $error("fifo_flex: AE_LEVEL out of range");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_ae;
   logic                  r_af;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;

   assign w_rd_ok   = rd & ~r_empty;
   // when full, a same-cycle pop frees the slot the write lands in
   assign w_wr_ok   = wr & (~r_full | rd);
   assign w_cnt_nxt = r_count
                    + {{ADDR_WIDTH{1'b0}}, w_wr_ok}
                    - {{ADDR_WIDTH{1'b0}}, w_rd_ok};

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ae    <= 1'b1;
         r_af    <= (AF_LEVEL == 0);
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= w_cnt_nxt;
         r_empty <= (w_cnt_nxt == '0);
         r_full  <= (w_cnt_nxt == DEP_L);
         r_ae    <= (w_cnt_nxt <= AE_L);
         r_af    <= (w_cnt_nxt >= AF_L);
         // a new error in the clearing cycle wins over the clear
         r_ovf   <= (r_ovf & ~err_clr) | (wr & ~w_wr_ok);
         r_udf   <= (r_udf & ~err_clr) | (rd & r_empty);
      end
   end

   assign r_data       = r_mem[r_rptr];
   assign empty        = r_empty;
   assign full         = r_full;
   assign almost_empty = r_ae;
   assign almost_full  = r_af;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: reference queue model checked
// against DUT data, count and flags every cycle.
module tb_fifo_flex;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          reset_n;
   logic          wr;
   logic [DW-1:0] w_data;
   logic          rd;
   logic [DW-1:0] r_data;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          err_clr;

   fifo_flex #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AF_LEVEL(14),
      .AE_LEVEL(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wr(wr),
      .w_data(w_data),
      .rd(rd),
      .r_data(r_data),
      .empty(empty),
      .full(full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow),
      .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        n_cmp = 0;
   int        n_err = 0;
   logic [7:0] sb[$];
   int        m_cnt = 0;
   bit        m_ovf = 0;
   bit        m_udf = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("count", 32'(count), 32'(m_cnt));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
      chk("almost_full", 32'(almost_full), 32'(m_cnt >= 14));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      if (m_cnt != 0) chk("head", 32'(r_data), 32'(sb[0]));
   endtask

   task automatic cyc(input bit w, input logic [7:0] d,
                      input bit r, input bit clr);
      bit rok;
      bit wok;
      rok = r && (m_cnt != 0);
      wok = w && ((m_cnt != DEPTH) || r);
      wr = w;
      w_data = d;
      rd = r;
      err_clr = clr;
      if (rok) begin
         chk("pop", 32'(r_data), 32'(sb[0]));
         void'(sb.pop_front());
      end
      if (wok) sb.push_back(d);
      m_cnt = m_cnt + int'(wok) - int'(rok);
      m_ovf = (m_ovf && !clr) || (w && !wok);
      m_udf = (m_udf && !clr) || (r && !rok);
      @(posedge clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
      err_clr = 1'b0;
      chk_state();
   endtask

   initial begin
      reset_n = 1'b0;
      wr = 1'b0;
      rd = 1'b0;
      err_clr = 1'b0;
      w_data = '0;
      #12;
      chk_state();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // fill 0x01..0x10, then one refused write
      for (int i = 1; i <= DEPTH; i++) cyc(1, 8'(i), 0, 0);
      cyc(1, 8'hEE, 0, 0);
      // drain in order, then one refused read
      for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 1);

      // rd+wr on empty: write taken, underflow set
      cyc(1, 8'hA5, 1, 0);
      chk("a5_head", 32'(r_data), 32'h0A5);
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 1, 0);

      // full with simultaneous rd+wr
      for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h40 + i), 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'h77, 1, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0);

      // random interleave
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 2) != 0), 8'($urandom),
             1'($urandom_range(0, 1)), 0);
      while (m_cnt > 0) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);

      // async reset mid-cycle with errors pending
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      m_cnt = 0;
      m_ovf = 0;
      m_udf = 0;
      chk_state();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1, 8'h3C, 0, 0);
      cyc(1, 8'h3D, 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
